alu_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one ALU among `N_REQ` requesters. Each requester presents operands and an opcode over a valid/ready handshake. The arbiter grants one requester at a time, drives the ALU operand bus, samples `Result`/`Error` after a fixed latency, and returns them tagged with the requester ID over a valid/ready response channel. It sits between the requester agents and the ALU's A/B/Opcode/Result/Error port.

---
 rtl/alu_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_rr_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter that time-shares one ALU among N_REQ requesters and
// returns each ALU result, tagged with the requester index, on a valid/ready channel.
module alu_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ALU_LAT = 1,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*32-1:0]   req_a,
    input  logic [N_REQ*32-1:0]   req_b,
    input  logic [N_REQ*3-1:0]    req_opcode,
    output logic signed [31:0]    alu_a,
    output logic [31:0]           alu_b,
    output logic [2:0]            alu_opcode,
    input  logic [31:0]           alu_result,
    input  logic                  alu_error,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic                  rsp_error,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(N_REQ);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr, cur_id, gnt_idx, rr_nxt;
    logic [ID_W:0]     scan, id_inc;
    logic              gnt_found;
    logic [2:0]        lat_cnt;
    logic              accept, exec_done, rsp_done;

    logic signed [31:0] a_arr [N_REQ];
    logic [31:0]        b_arr [N_REQ];
    logic [2:0]         op_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign a_arr[i]  = req_a[i*32 +: 32];
        assign b_arr[i]  = req_b[i*32 +: 32];
        assign op_arr[i] = req_opcode[i*3 +: 3];
    end

    // Grant: first valid requester at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan >= NREQ_W)
                scan = scan - NREQ_W;
            if (!gnt_found && req_valid[scan[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && gnt_found)
            req_ready[gnt_idx] = 1'b1;
    end

    assign id_inc    = {1'b0, cur_id} + (ID_W+1)'(1);
    assign rr_nxt    = (id_inc >= NREQ_W) ? '0 : id_inc[ID_W-1:0];
    assign accept    = (state_q == IDLE) && gnt_found;
    assign exec_done = (state_q == EXEC) && (lat_cnt == 3'd1);
    assign rsp_done  = (state_q == RESP) && rsp_valid && rsp_ready;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = EXEC;
            EXEC:    if (exec_done) state_d = RESP;
            RESP:    if (rsp_done)  state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Operand launch on accept, result capture after ALU_LAT edges, pointer update on response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            cur_id     <= '0;
            lat_cnt    <= '0;
            rr_ptr     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
        end else begin
            if (accept) begin
                alu_a      <= a_arr[gnt_idx];
                alu_b      <= b_arr[gnt_idx];
                alu_opcode <= op_arr[gnt_idx];
                cur_id     <= gnt_idx;
                lat_cnt    <= 3'(ALU_LAT);
            end
            if (state_q == EXEC)
                lat_cnt <= lat_cnt - 3'd1;
            if (exec_done) begin
                rsp_result <= alu_result;
                rsp_error  <= alu_error;
                rsp_id     <= cur_id;
                rsp_valid  <= 1'b1;
            end
            if (rsp_done) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= rr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: a one-cycle ALU instance checked through a
// response scoreboard, plus a three-cycle-latency instance with a bench-driven result.
module tb_alu_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] ta [4];
    logic [31:0] tb_ [4];
    logic [2:0]  to [4];
    logic [127:0] req_a, req_b;
    logic [11:0]  req_opcode;
    logic        rsp_ready;

    assign req_a      = {ta[3], ta[2], ta[1], ta[0]};
    assign req_b      = {tb_[3], tb_[2], tb_[1], tb_[0]};
    assign req_opcode = {to[3], to[2], to[1], to[0]};

    logic [3:0]         req_ready, req_ready3;
    logic signed [31:0] alu_a, alu_a3;
    logic [31:0]        alu_b, alu_b3;
    logic [2:0]         alu_opcode, alu_opcode3;
    logic [31:0]        alu_result, alu_result3;
    logic               alu_error, alu_error3;
    logic               rsp_valid, rsp_valid3;
    logic [1:0]         rsp_id, rsp_id3;
    logic [31:0]        rsp_result, rsp_result3;
    logic               rsp_error, rsp_error3;
    logic               busy, busy3;

    alu_rr_arbiter #(.N_REQ(4), .ALU_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_error(alu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_error(rsp_error),
        .busy(busy)
    );

    alu_rr_arbiter #(.N_REQ(4), .ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready3),
        .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(alu_opcode3),
        .alu_result(alu_result3), .alu_error(alu_error3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id3), .rsp_result(rsp_result3), .rsp_error(rsp_error3),
        .busy(busy3)
    );

    // Reference ALU: {error, result}
    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [31:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            default: r = a ^ b;
        endcase
        if (a == 32'h7FFF_FFFF && b == 32'd1)
            return {1'b1, 32'h8000_0000};
        return {1'b0, r};
    endfunction

    always_comb {alu_error, alu_result} = alu_ref(alu_a, alu_b, alu_opcode);

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        ta[i]  = a;
        tb_[i] = b;
        to[i]  = op;
    endtask

    task automatic push_ref(input logic [1:0] i);
        logic [32:0] r;
        r = alu_ref(ta[i], tb_[i], to[i]);
        sb.push_back('{id: i, res: r[31:0], err: r[32]});
    endtask

    // Wait (bounded) for a response on the ALU_LAT=1 instance, compare, complete handshake
    task automatic collect(input int budget);
        exp_t e;
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rsp_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("rsp_timeout", 32'(found), 32'd1);
        if (found) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_error", 32'(rsp_error), 32'(e.err));
            end
            step();
            chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        rst         = 1'b0;
        req_valid   = '0;
        rsp_ready   = 1'b1;
        alu_result3 = '0;
        alu_error3  = 1'b0;
        for (int k = 0; k < 4; k++) set_req(2'(k), 32'd0, 32'd0, 3'd0);
        repeat (2) step();

        // Reset state
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        step();

        // Single op from requester 2: 5 + 3
        set_req(2'd2, 32'd5, 32'd3, 3'd0);
        req_valid = 4'b0100;
        #1;
        chk("single_req_ready", 32'(req_ready), 32'h4);
        sb.push_back('{id: 2'd2, res: 32'd8, err: 1'b0});
        step();
        req_valid = '0;
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_alu_a", alu_a, 32'd5);
        chk("single_alu_b", alu_b, 32'd3);
        chk("single_rsp_early", 32'(rsp_valid), 32'd0);
        step();
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        collect(4);
        chk("single_idle", 32'(busy), 32'd0);

        // Round-robin with all requesters valid, starting from reset
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        for (int k = 0; k < 4; k++) set_req(2'(k), 32'(100 + k), 32'(k), 3'd0);
        req_valid = 4'hF;
        for (int n = 0; n < 8; n++) begin
            logic [1:0] g;
            g = 2'(n);
            #1;
            chk("rr_grant", 32'(req_ready), 32'd1 << g);
            push_ref(g);
            step();
            collect(6);
        end
        req_valid = '0;

        // Response backpressure on requester 1
        set_req(2'd1, 32'd100, 32'd23, 3'd0);
        req_valid = 4'b0010;
        sb.push_back('{id: 2'd1, res: 32'd123, err: 1'b0});
        step();
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_id", 32'(rsp_id), 32'd1);
            chk("bp_rsp_result", rsp_result, 32'd123);
            chk("bp_alu_a", alu_a, 32'd100);
            chk("bp_alu_b", alu_b, 32'd23);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            step();
        end
        rsp_ready = 1'b1;
        collect(2);
        chk("bp_next_grant", 32'(req_ready), 32'h4);
        req_valid = '0;
        step();
        chk("bp_idle", 32'(busy), 32'd0);

        // Error passthrough from requester 3
        set_req(2'd3, 32'h7FFF_FFFF, 32'd1, 3'd0);
        req_valid = 4'b1000;
        sb.push_back('{id: 2'd3, res: 32'h8000_0000, err: 1'b1});
        #1;
        chk("err_req_ready", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        collect(6);

        // ALU_LAT=3: result present at t+2 must not be the one captured
        rst = 1'b0;
        step();
        chk("lat_rst_busy", 32'(busy3), 32'd0);
        rst = 1'b1;
        alu_result3 = 32'hDEAD_0000;
        set_req(2'd0, 32'd7, 32'd9, 3'd0);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        chk("lat_alu_a", alu_a3, 32'd7);
        chk("lat_busy", 32'(busy3), 32'd1);
        step();
        chk("lat_t1_rsp", 32'(rsp_valid3), 32'd0);
        step();
        chk("lat_t2_rsp", 32'(rsp_valid3), 32'd0);
        alu_result3 = 32'd16;
        step();
        chk("lat_t3_rsp", 32'(rsp_valid3), 32'd1);
        chk("lat_result", rsp_result3, 32'd16);
        chk("lat_id", 32'(rsp_id3), 32'd0);
        step();
        chk("lat_rsp_drop", 32'(rsp_valid3), 32'd0);
        chk("lat_idle", 32'(busy3), 32'd0);

        // Reset while executing: op from requester 2 is discarded
        set_req(2'd2, 32'd11, 32'd22, 3'd0);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        chk("rx_busy", 32'(busy), 32'd1);
        chk("rx_busy3", 32'(busy3), 32'd1);
        rst = 1'b0;
        #1;
        chk("rx_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rx_busy_clr", 32'(busy), 32'd0);
        chk("rx_rsp_valid3", 32'(rsp_valid3), 32'd0);
        chk("rx_busy3_clr", 32'(busy3), 32'd0);
        chk("rx_rsp_result", rsp_result, 32'd0);
        step();
        step();
        chk("rx_no_rsp", 32'(rsp_valid), 32'd0);
        chk("rx_no_rsp3", 32'(rsp_valid3), 32'd0);
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("rx_grant0", 32'(req_ready), 32'h1);
        chk("rx_grant0_3", 32'(req_ready3), 32'h1);
        req_valid = '0;
        step();
        chk("rx_idle", 32'(busy), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
